// File: rtl/ppe_pkg.sv
// Shared constants and FSM state type for the round-robin grant scheduler.
// Imported by the encoder and the scheduler top.
package ppe_pkg;

  localparam int PPE_N = 512;
  localparam int PPE_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    S1,
    S2,
    GRANT
  } state_t;

endpackage

// File: rtl/ppe_w512_c.sv
// 512-way registered programmable priority encoder, two-cycle latency:
// first set bit at or above p_enc, searching cyclically.
module ppe_w512_c
  import ppe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PPE_N-1:0] req,
  input  logic [PPE_W-1:0] p_enc,
  output logic [PPE_W-1:0] o_value,
  output logic             valid
);

  logic [PPE_N-1:0]   req_q;
  logic [PPE_W-1:0]   p_q;
  logic [2*PPE_N-1:0] dbl;
  logic [PPE_N-1:0]   rot;
  logic [PPE_W-1:0]   off;
  logic [PPE_W-1:0]   hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      p_q   <= '0;
    end else begin
      req_q <= req;
      p_q   <= p_enc;
    end
  end

  // Rotate so the pointer lands on bit 0, then take the lowest set bit.
  always_comb begin
    dbl = {req_q, req_q} >> p_q;
    rot = dbl[PPE_N-1:0];
    off = '0;
    for (int i = PPE_N - 1; i >= 0; i--) begin
      if (rot[i]) off = i[PPE_W-1:0];
    end
    hit = off + p_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_value <= '0;
      valid   <= 1'b0;
    end else begin
      o_value <= hit;
      valid   <= |req_q;
    end
  end

endmodule

// File: rtl/ppe_rr_sched.sv
// Round-robin grant scheduler over the registered 512-way encoder.
// Define PPE_SCHED_REVALIDATE_EN to drop a held grant whose request vanished.
module ppe_rr_sched
  import ppe_pkg::*;
#(
  parameter int PTR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PPE_N-1:0] req,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [PPE_W-1:0] gnt_idx,
  output logic             busy,
  output logic [PPE_W-1:0] ptr
);

  localparam logic [PPE_W-1:0] PTR_RST = PPE_W'(PTR_INIT);

  state_t           state;
  state_t           state_d;
  logic [PPE_W-1:0] enc_value;
  logic             enc_valid;
  logic             lat;
  logic             acc;

  ppe_w512_c u_enc (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .p_enc   (ptr),
    .o_value (enc_value),
    .valid   (enc_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // S2 sees the encoder result for the request sampled in IDLE.
  always_comb begin
    state_d = state;
    lat     = 1'b0;
    acc     = 1'b0;
    unique case (state)
      IDLE: if (|req) state_d = S1;
      S1:   state_d = S2;
      S2: begin
        if (enc_valid) begin
          state_d = GRANT;
          lat     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          state_d = IDLE;
          acc     = 1'b1;
        end
`ifdef PPE_SCHED_REVALIDATE_EN
        else if (!req[gnt_idx]) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_idx <= '0;
      ptr     <= PTR_RST;
    end else begin
      if (lat) gnt_idx <= enc_value;
      if (acc) ptr <= gnt_idx + PPE_W'(1);
    end
  end

  assign gnt_valid = (state == GRANT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ppe_rr_sched.sv
// Scoreboard bench for ppe_rr_sched: transaction-level round-robin model
// feeds expected grants; a negedge monitor compares what the DUT presents.
module tb_ppe_rr_sched;

  localparam int PI = 510;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] req = '0;
  logic         gnt_ready = 1'b0;
  logic         gnt_valid;
  logic [8:0]   gnt_idx;
  logic         busy;
  logic [8:0]   ptr;

  ppe_rr_sched #(.PTR_INIT(PI)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ready (gnt_ready),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .busy      (busy),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cycle;
    int idx;
    int ptr_n;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state (transaction level).
  bit m_busy = 0;
  int m_ptr = PI;
  int m_idx = 0;
  int m_gstart = 0;
  bit exp_valid = 0;
  int exp_idx = 0;
  int mon_ptr = PI;

  task automatic chk(input string nm, input longint a, input longint e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  function automatic int search(input logic [511:0] r, input int p);
    for (int k = 0; k < 512; k++) begin
      int j;
      j = (p + k) % 512;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [511:0] rand_req();
    logic [511:0] r;
    int mode;
    r = '0;
    mode = $urandom_range(0, 3);
    if (mode == 1) begin
      r[$urandom_range(0, 511)] = 1'b1;
    end else if (mode == 2) begin
      for (int k = 0; k < 3; k++) r[$urandom_range(0, 511)] = 1'b1;
    end else if (mode == 3) begin
      for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    end
    return r;
  endfunction

  task automatic step(input logic [511:0] r, input logic rdy);
    @(posedge clk);
    #1;
    req = r;
    gnt_ready = rdy;
    if (!m_busy) begin
      exp_valid = 0;
      if (|r) begin
        m_busy = 1;
        m_idx = search(r, m_ptr);
        m_gstart = cyc + 3;
      end
    end else begin
      exp_valid = (cyc >= m_gstart);
      if (exp_valid && rdy) begin
        sb.push_back('{cyc, m_idx, (m_idx + 1) % 512});
        m_ptr = (m_idx + 1) % 512;
        m_busy = 0;
      end
    end
    exp_idx = m_idx;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    gnt_ready = 1'b0;
    #1;
    chk("rst_valid", gnt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ptr", ptr, PI);
    chk("rst_idx", gnt_idx, 0);
    repeat (2) @(posedge clk);
    #1;
    m_busy = 0;
    m_ptr = PI;
    exp_valid = 0;
    rst = 1'b0;
  endtask

  // Monitor: per-cycle valid/idx/ptr checks plus scoreboard pops.
  always @(negedge clk) begin
    if (rst) begin
      mon_ptr = PI;
    end else begin
      chk("valid", gnt_valid, exp_valid);
      if (exp_valid) chk("idx_hold", gnt_idx, exp_idx);
      chk("ptr", ptr, mon_ptr);
      if (gnt_valid && gnt_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("grant_cycle", cyc, e.cycle);
          chk("grant_idx", gnt_idx, e.idx);
          mon_ptr = e.ptr_n;
        end
      end
    end
  end

  initial begin
    logic [511:0] r;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", gnt_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_ptr", ptr, PI);
    chk("init_idx", gnt_idx, 0);
    rst = 1'b0;

    // Wrap: 511 then 2 from PTR_INIT=510.
    r = '0;
    r[511] = 1'b1;
    r[2] = 1'b1;
    repeat (12) step(r, 1'b1);
    repeat (4) step('0, 1'b1);

    // Single requester.
    r = '0;
    r[5] = 1'b1;
    repeat (12) step(r, 1'b1);
    repeat (4) step('0, 1'b1);

    // Fairness across three requesters.
    r = '0;
    r[3] = 1'b1;
    r[100] = 1'b1;
    r[400] = 1'b1;
    repeat (16) step(r, 1'b1);
    repeat (4) step('0, 1'b1);

    // Backpressure.
    r = '0;
    r[7] = 1'b1;
    repeat (14) step(r, 1'b0);
    repeat (3) step(r, 1'b1);
    repeat (4) step('0, 1'b1);

    // Withdrawal: one-cycle pulse in IDLE, then held grant.
    r = '0;
    r[9] = 1'b1;
    step(r, 1'b0);
    repeat (8) step('0, 1'b0);

    // Reset while the grant is held.
    do_reset();
    r = '0;
    r[20] = 1'b1;
    repeat (8) step(r, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) r = rand_req();
      step(r, 1'($urandom_range(0, 1)));
    end
    repeat (12) step('0, 1'b1);

    @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ppe_rr_sched.md
# ppe_rr_sched

Round-robin grant scheduler built around the 512-way registered programmable priority encoder. Owns the encoder's priority pointer, samples a 512-bit request vector, and issues one grant at a time over a valid/ready handshake. After each accepted grant it advances the pointer one past the winner, so every requester is served fairly. It sits between the requesting agents and the shared resource those agents contend for.

## Interface
- PTR_INIT, 0: pointer value after reset (0..511).
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  512  request vector; bit i set = requester i wants service; may change any cycle.
- gnt_ready  in  1  consumer accepts the current grant this cycle.
- gnt_valid  out  1  grant presented.
- gnt_idx  out  9  index of the granted requester; stable while gnt_valid=1 and gnt_ready=0.
- busy  out  1  state != IDLE.
- ptr  out  9  current priority pointer; for observability.

## Operation
- Encoder contract: inputs Req/P_enc applied in cycle c produce o_value/valid in cycle c+2. o_value is the first set bit at or above P_enc, searching cyclically (511 wraps to 0). valid = |Req. The encoder is reset together with this block; its outputs reset to 0.
- Encoder Req is driven directly from req. Encoder P_enc is driven from ptr.
- States: IDLE, S1, S2, GRANT.
- IDLE: if |req then S1, else stay.
- S1: go to S2 unconditionally. No re-check of req.
- S2: the encoder output reflects the IDLE-cycle inputs.
  - If encoder valid: latch gnt_idx <= o_value and go to GRANT.
  - Else: go to IDLE with no grant.
- GRANT: gnt_valid=1.
  - If gnt_ready: ptr <= gnt_idx+1 mod 512 (9-bit natural wrap; 511 -> 0), then go to IDLE.
  - Else: hold the state, gnt_idx and ptr.
- The pointer changes only on an accepted grant.
- Request changes while in S1, S2 or GRANT do not alter an outstanding grant (unless the macro below is defined).
- Reset values: gnt_valid=0, gnt_idx=0, busy=0, ptr=PTR_INIT, state=IDLE.

## Timing
- req rises in cycle c (state IDLE) -> S1 in c+1, S2 in c+2, gnt_valid=1 in c+3.
- gnt_ready high in the same cycle gnt_valid rises -> accepted that cycle. gnt_valid=0 and the new ptr are visible the next cycle (IDLE).
- Minimum spacing between accepted grants is 4 cycles: IDLE, S1, S2, GRANT.
- gnt_ready while gnt_valid=0 is ignored.
- req withdrawn after the IDLE sample is still granted (the stale sample is honoured). An all-zero sample produces no grant and returns to IDLE.
- Reset asserted in any state forces the reset values immediately. The first possible grant is 3 cycles after reset deassertion, provided req is nonzero.

## Configuration
- PPE_SCHED_REVALIDATE_EN defined:
  - In GRANT, if req[gnt_idx]=0 and gnt_ready=0, drop the grant: gnt_valid goes 0 next cycle, state goes to IDLE, ptr is unchanged.
  - If gnt_ready=1 in the same cycle, acceptance wins.
- Not defined: a grant is held until gnt_ready regardless of req.

## Structure
- Shared package ppe_pkg holds:
  - localparams PPE_N=512 and PPE_W=9;
  - the state enum (IDLE, S1, S2, GRANT).
- One sub-module: ppe_w512_c (the registered encoder), instantiated once. Its rst is tied to rst.
- Everything else (FSM, pointer, grant registers) is flat in ppe_rr_sched.

## Test plan
- Single requester: PTR_INIT=0, req[5]=1 from cycle 0, gnt_ready=1. Required: gnt_valid in cycle 3 with gnt_idx=5, then ptr=6. Repeats every 4 cycles with gnt_idx=5 and ptr=6.
- Fairness: req bits 3, 100 and 400 held high, gnt_ready=1. Required grant sequence: 3, 100, 400, 3, with ptr=4, 101, 401, 4.
- Wrap: PTR_INIT=510, req bits 511 and 2. Required: gnt_idx=511 and ptr becomes 0, then gnt_idx=2 and ptr becomes 3.
- Backpressure: req[7]=1, gnt_ready=0 for 10 cycles, then 1. Required: gnt_valid=1 and gnt_idx=7 stable for the whole hold; ptr stays 0 until acceptance, then 8.
- Withdrawal: req[9] pulses only in one IDLE cycle, gnt_ready=0. Required:
  - macro off: grant 9 is still issued and held;
  - macro on: gnt_valid drops one cycle after GRANT entry, ptr unchanged.
- Reset: rst asserted while in GRANT. Required: gnt_valid=0, busy=0 and ptr=PTR_INIT immediately; no grant for 3 cycles after release.
